// File: rtl/fetch_unit.sv
// Fetch stage: owns PCF, issues one outstanding imem request, queues up to two returned instructions for decode.
// A response is visible to decode the cycle after it returns; a request is withheld unless a queue slot is guaranteed.
module fetch_unit #(
  parameter int                         ADDRESS_WIDTH = 8,
  parameter int                         DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic                     imem_rvalid,
  input  logic [DATA_WIDTH-1:0]    imem_rdata,
  input  logic                     PCSrcE,
  input  logic [ADDRESS_WIDTH-1:0] PCTargetE,
  input  logic                     StallD,
  input  logic                     FlushD,
  output logic [DATA_WIDTH-1:0]    instrD,
  output logic [ADDRESS_WIDTH-1:0] PCD,
  output logic [ADDRESS_WIDTH-1:0] PCPlus4D,
  output logic                     ValidD
);

  localparam logic [DATA_WIDTH-1:0]    NOP     = DATA_WIDTH'(32'h00000013);
  localparam logic [ADDRESS_WIDTH-1:0] PC_STEP = ADDRESS_WIDTH'(4);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]    instr;
    logic [ADDRESS_WIDTH-1:0] pc;
    logic [ADDRESS_WIDTH-1:0] pc_plus4;
  } entry_t;

  state_t                     state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]   pcf_q, pcf_d;
  logic [ADDRESS_WIDTH-1:0]   pc_pend_q, pc_pend_d;
  entry_t                     head_q, head_d;
  entry_t                     tail_q, tail_d;
  logic [1:0]                 count_q, count_d;

  logic                       push;
  logic                       pop;
  logic                       issue;
  logic [2:0]                 occ_post;
  entry_t                     new_entry;

  always_comb begin
    new_entry.instr    = imem_rdata;
    new_entry.pc       = pc_pend_q;
    new_entry.pc_plus4 = pc_pend_q + PC_STEP;

    push     = (state_q == WAIT) && imem_rvalid && !PCSrcE;
    pop      = (count_q != 2'd0) && !StallD && !PCSrcE && !FlushD;
    occ_post = {1'b0, count_q} + {2'b00, push} - {2'b00, pop};
    // Only issue when the response is certain to find a free slot.
    issue    = !PCSrcE
             && ((state_q == IDLE) || ((state_q == WAIT) && imem_rvalid))
             && (occ_post <= 3'd1);

    state_d = state_q;
    unique case (state_q)
      IDLE: if (issue) state_d = WAIT;
      WAIT: begin
        if (imem_rvalid)  state_d = issue ? WAIT : IDLE;
        else if (PCSrcE)  state_d = DROP;
      end
      DROP: if (imem_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    pcf_d     = PCSrcE ? PCTargetE : (issue ? pcf_q + PC_STEP : pcf_q);
    pc_pend_d = issue ? pcf_q : pc_pend_q;

    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (PCSrcE || FlushD) begin
      count_d = 2'd0;
    end else begin
      count_d = occ_post[1:0];
      if (pop && (count_q == 2'd2)) head_d = tail_q;
      if (push) begin
        if ((count_q == 2'd0) || (pop && (count_q == 2'd1))) head_d = new_entry;
        else                                                  tail_d = new_entry;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      pcf_q     <= RESET_PC;
      pc_pend_q <= RESET_PC;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= 2'd0;
    end else begin
      state_q   <= state_d;
      pcf_q     <= pcf_d;
      pc_pend_q <= pc_pend_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

  // Gated by reset so nothing is requested while the block is held in reset.
  assign imem_req  = issue && rst;
  assign imem_addr = pcf_q;
  assign ValidD    = (count_q != 2'd0);
  assign instrD    = ValidD ? head_q.instr : NOP;
  assign PCD       = head_q.pc;
  assign PCPlus4D  = head_q.pc_plus4;

endmodule
